uart_frame_assembler: RTL and testbench
=======================================

# uart_frame_assembler

Parametrised command-frame assembler sitting between the UART receiver and the datapath. It collects a byte stream of one opcode byte followed by `NUM_OPERANDS` operands of `DATA_BYTES` bytes each. A completed frame is presented on registered outputs with a valid/ready handshake. Partial frames are discarded on an inter-byte timeout, and bytes arriving while a frame is unconsumed are reported as overruns.

## Interface
- `DATA_BYTES`, default 1: bytes per operand (≥1).
- `NUM_OPERANDS`, default 2: operands per frame (≥1).
- `TIMEOUT_CYCLES`, default 50000: maximum idle clocks between bytes inside a frame (≥2; 1 ms at 50 MHz).
- `clk` input 1: system clock, 50 MHz.
- `reset_n` input 1: reset, asynchronous and active-low.
- `rx_data_ready` input 1: one-cycle strobe from the UART; `rx_data` is valid in this cycle.
- `rx_data` input 8: received byte.
- `frame_ready` input 1: consumer accepts the frame when high in the same cycle as `frame_valid`.
- `frame_valid` output 1: the completed frame is available on `operation` and `operands`.
- `operation` output 8: opcode byte of the last completed frame.
- `operands` output `NUM_OPERANDS*DATA_BYTES*8`: operand k occupies bits `[(k+1)*DATA_BYTES*8-1 : k*DATA_BYTES*8]`.
- `busy` output 1: high while a frame is partially received (COLLECT).
- `frame_error` output 1: one-cycle pulse reporting an error.
- `err_code` output 2: error cause, held until the next error or reset. 01 = timeout, 10 = overrun, 00 = none.

## Operation
- Frame length is `FRAME_LEN = 1 + NUM_OPERANDS*DATA_BYTES` bytes.
  - Byte 0 is the opcode.
  - Operand bytes follow in operand order, operand 0 first.
  - Within an operand, the most significant byte comes first.
- Byte counter and timeout counter widths are `$clog2` of their ranges. No arithmetic is performed on the data.
- Incoming bytes go into a staging shift register. `operation` and `operands` are loaded only when a frame completes, so they always hold the last complete frame.
- States:
  - **IDLE**:
    - A byte strobe stores the opcode, sets count=1 and enters COLLECT.
    - If `FRAME_LEN` would be 1, that is impossible here because `NUM_OPERANDS` and `DATA_BYTES` are both ≥1.
  - **COLLECT**:
    - Each strobe shifts in the byte, increments count and clears the timeout counter.
    - On the strobe carrying byte `FRAME_LEN-1`: load the output registers from staging plus `rx_data`, set `frame_valid`, and enter HOLD.
  - **COLLECT timeout**:
    - The timeout counter increments on every cycle without a strobe.
    - When it reaches `TIMEOUT_CYCLES`: discard the staging data, pulse `frame_error` with `err_code`=01, and return to IDLE.
    - Output registers are not changed.
  - **HOLD**:
    - `frame_valid`=1, and the outputs are stable.
    - `frame_ready`=1 clears `frame_valid` and returns to IDLE.
    - A strobe without `frame_ready` drops the byte and pulses `frame_error` with `err_code`=10. The state stays HOLD.
- Simultaneous events:
  - Strobe in the same cycle the timeout counter would expire: the byte is accepted and the counter is cleared. There is no error.
  - `frame_ready` and a strobe in the same HOLD cycle: the frame is consumed and the byte is taken as the opcode of the next frame. The state goes to COLLECT, count=1, with no error.
  - `frame_ready` while `frame_valid`=0: ignored.
- Reset, asynchronous, also when asserted mid-frame:
  - State=IDLE; count and timeout counter = 0.
  - `frame_valid`=0, `busy`=0, `frame_error`=0, `err_code`=00.
  - `operation`=0, `operands`=0, staging=0.

## Timing
- `rx_data` is sampled on the rising edge where `rx_data_ready`=1. The block is always ready for a byte; there is no backpressure toward the UART.
- Latency: `frame_valid`, `operation` and `operands` update on the same edge that samples the last byte, so they are visible 1 cycle after that strobe cycle.
- `frame_valid` falls on the edge where `frame_valid`=1 and `frame_ready`=1. The minimum frame period is `FRAME_LEN` strobes; back-to-back strobes on every clock are supported.
- `busy` rises on the edge that samples the opcode and falls on the completion or timeout edge.
- The `frame_error` pulse lasts exactly 1 cycle, on the edge following the error condition. `err_code` updates on the same edge.
- The timeout fires on the `TIMEOUT_CYCLES`-th consecutive strobe-free cycle after the last accepted byte.

## Test plan
- **Basic frame** (defaults, `frame_ready`=1):
  - Stimulus: strobes 0x2B, 0x12, 0x34.
  - Required: `operation`=0x2B, `operands`=0x3412 (operand0=0x12, operand1=0x34), and `frame_valid` high for 1 cycle, starting 1 cycle after the 3rd strobe.
- **Wide operands** (`DATA_BYTES`=2, `NUM_OPERANDS`=2):
  - Stimulus: strobes 0x01, 0xAB, 0xCD, 0x12, 0x34.
  - Required: operand0=0xABCD, operand1=0x1234, `operation`=0x01.
- **Timeout** (`TIMEOUT_CYCLES`=10):
  - Stimulus: strobes 0x05, 0x07, then 10 idle cycles, then a full frame 0x06, 0x01, 0x02.
  - Required: one `frame_error` pulse with `err_code`=01 and no `frame_valid` for the partial frame; the next frame yields `operation`=0x06.
  - Repeat with the next strobe on idle cycle 10: no error.
- **Overrun and simultaneous consume**:
  - Stimulus: hold `frame_ready`=0 after a frame completes, then strobe 0x99.
  - Required: `frame_error` with `err_code`=10, and the outputs are unchanged.
  - Then assert `frame_ready` together with strobe 0x2D: the frame is consumed, `busy`=1, and 0x2D becomes the next opcode.
- **Back-to-back**: 3 frames of strobes on consecutive clocks with `frame_ready`=1 → 3 `frame_valid` pulses, each with the correct data.
- **Reset mid-frame**: assert `reset_n`=0 after 2 bytes → all outputs 0 immediately. After release, a fresh 3-byte frame completes correctly.

Source files
------------

// File: rtl/uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_assembler
// Purpose  : Collects an opcode byte plus NUM_OPERANDS operands of DATA_BYTES
//            bytes from a UART byte stream and presents the completed frame
//            on registered outputs with a valid/ready handshake. Drops partial
//            frames on inter-byte timeout and flags bytes that arrive while a
//            frame is still unconsumed.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_assembler #(
  parameter int DATA_BYTES     = 1,
  parameter int NUM_OPERANDS   = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 rx_data_ready,
  input  logic [7:0]                           rx_data,
  input  logic                                 frame_ready,
  output logic                                 frame_valid,
  output logic [7:0]                           operation,
  output logic [NUM_OPERANDS*DATA_BYTES*8-1:0] operands,
  output logic                                 busy,
  output logic                                 frame_error,
  output logic [1:0]                           err_code
);

  localparam int OB        = DATA_BYTES * 8;
  localparam int OPW       = NUM_OPERANDS * OB;
  localparam int FRAME_LEN = 1 + NUM_OPERANDS * DATA_BYTES;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]       ERR_OVERRUN = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  // Staging holds every byte of the frame except the last one; the last
  // byte is taken straight from rx_data on the completion edge.
  logic [OPW-1:0]   r_staging;
  logic [OPW+7:0]   w_shift;
  logic [OPW-1:0]   w_operands;

  logic w_start;
  logic w_collect;
  logic w_complete;
  logic w_timeout;
  logic w_overrun;
  logic w_consume;

  // Full frame image: opcode in the top byte, operand bytes in arrival order.
  assign w_shift = {r_staging, rx_data};

  // Operand 0 arrives first (highest in w_shift) but lives in the lowest slice.
  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_operands
    assign w_operands[k*OB +: OB] = w_shift[OPW-1-k*OB -: OB];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and per-cycle event flags.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_collect    = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_data_ready) begin
          w_start      = 1'b1;
          w_state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_data_ready) begin
          if (r_byte_cnt == LAST_BYTE) begin
            w_complete   = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_collect = 1'b1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          w_consume = 1'b1;
          if (rx_data_ready) begin
            w_start      = 1'b1;
            w_state_next = COLLECT;
          end else begin
            w_state_next = IDLE;
          end
        end else if (rx_data_ready) begin
          w_overrun = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Byte staging, byte counter and inter-byte timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_staging  <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (w_start || w_collect) r_staging <= w_shift[OPW-1:0];
      else if (w_timeout)       r_staging <= '0;

      if (w_start)                      r_byte_cnt <= CNT_W'(1);
      else if (w_collect)               r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      else if (w_complete || w_timeout) r_byte_cnt <= '0;

      // Counts strobe-free cycles inside a frame; any byte or exit clears it.
      if (r_state == COLLECT && !rx_data_ready && !w_timeout)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      else
        r_to_cnt <= '0;
    end
  end

  // Output frame registers and handshake flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      operation   <= '0;
      operands    <= '0;
    end else begin
      if (w_complete) begin
        frame_valid <= 1'b1;
        operation   <= w_shift[OPW+7:OPW];
        operands    <= w_operands;
      end else if (w_consume) begin
        frame_valid <= 1'b0;
      end
    end
  end

  // Error pulse, sticky error cause and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
      err_code    <= 2'b00;
      busy        <= 1'b0;
    end else begin
      frame_error <= w_timeout || w_overrun;
      if (w_timeout)      err_code <= ERR_TIMEOUT;
      else if (w_overrun) err_code <= ERR_OVERRUN;
      busy <= (w_state_next == COLLECT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_assembler
// Purpose  : Directed self-checking bench with frame and error scoreboards
//            for uart_frame_assembler (1-byte and 2-byte operand builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  // Narrow build: DATA_BYTES=1, NUM_OPERANDS=2, short timeout.
  logic        rx_data_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [7:0]  operation;
  logic [15:0] operands;
  logic        busy;
  logic        frame_error;
  logic [1:0]  err_code;

  // Wide build: DATA_BYTES=2, NUM_OPERANDS=2.
  logic        w_rx_ready = 1'b0;
  logic [7:0]  w_rx_data = '0;
  logic        w_ready = 1'b1;
  logic        w_valid;
  logic [7:0]  w_operation;
  logic [31:0] w_operands;
  logic        w_busy;
  logic        w_error;
  logic [1:0]  w_err_code;

  int checks = 0;
  int failures = 0;

  logic [23:0] frame_q[$];
  logic [39:0] wide_q[$];
  logic [1:0]  err_q[$];

  uart_frame_assembler #(
    .DATA_BYTES(1), .NUM_OPERANDS(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .frame_ready(frame_ready), .frame_valid(frame_valid),
    .operation(operation), .operands(operands),
    .busy(busy), .frame_error(frame_error), .err_code(err_code)
  );

  uart_frame_assembler #(
    .DATA_BYTES(2), .NUM_OPERANDS(2), .TIMEOUT_CYCLES(10)
  ) dut_w (
    .clk(clk), .reset_n(reset_n),
    .rx_data_ready(w_rx_ready), .rx_data(w_rx_data),
    .frame_ready(w_ready), .frame_valid(w_valid),
    .operation(w_operation), .operands(w_operands),
    .busy(w_busy), .frame_error(w_error), .err_code(w_err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] b);
    w_rx_data  = b;
    w_rx_ready = 1'b1;
    @(posedge clk);
    #1;
    w_rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame scoreboard: compare at every accepted handshake.
  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      if (frame_q.size() == 0) check("frame_unexpected", 64'(frame_q.size()), 64'd1);
      else check("frame_data", {40'd0, operation, operands}, {40'd0, frame_q.pop_front()});
    end
    if (reset_n && w_valid && w_ready) begin
      if (wide_q.size() == 0) check("wide_unexpected", 64'(wide_q.size()), 64'd1);
      else check("wide_data", {24'd0, w_operation, w_operands}, {24'd0, wide_q.pop_front()});
    end
    if (reset_n && frame_error) begin
      if (err_q.size() == 0) check("err_unexpected", 64'(err_q.size()), 64'd1);
      else check("err_code", {62'd0, err_code}, {62'd0, err_q.pop_front()});
    end
    if (reset_n && w_error) check("wide_err_unexpected", {63'd0, w_error}, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    check("rst_valid", {63'd0, frame_valid}, 64'd0);
    check("rst_busy",  {63'd0, busy},        64'd0);
    check("rst_error", {63'd0, frame_error}, 64'd0);
    check("rst_code",  {62'd0, err_code},    64'd0);
    check("rst_op",    {56'd0, operation},   64'd0);
    check("rst_opnds", {48'd0, operands},    64'd0);
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    idle(1);

    // Basic frame.
    frame_q.push_back({8'h2B, 16'h3412});
    send(8'h2B);
    check("basic_busy", {63'd0, busy}, 64'd1);
    send(8'h12);
    send(8'h34);
    check("basic_valid_lat", {63'd0, frame_valid}, 64'd1);
    check("basic_busy_fall", {63'd0, busy}, 64'd0);
    idle(1);
    check("basic_valid_1cyc", {63'd0, frame_valid}, 64'd0);

    // Wide operands.
    wide_q.push_back({8'h01, 16'h1234, 16'hABCD});
    send_w(8'h01); send_w(8'hAB); send_w(8'hCD); send_w(8'h12); send_w(8'h34);
    check("wide_valid", {63'd0, w_valid}, 64'd1);
    idle(1);

    // Timeout on a partial frame, then a clean frame.
    send(8'h05); send(8'h07);
    idle(9);
    check("to_pre_error", {63'd0, frame_error}, 64'd0);
    check("to_pre_busy",  {63'd0, busy},        64'd1);
    err_q.push_back(2'b01);
    idle(1);
    check("to_error", {63'd0, frame_error}, 64'd1);
    check("to_busy",  {63'd0, busy},        64'd0);
    check("to_valid", {63'd0, frame_valid}, 64'd0);
    idle(1);
    check("to_pulse_1cyc", {63'd0, frame_error}, 64'd0);
    frame_q.push_back({8'h06, 16'h0201});
    send(8'h06); send(8'h01); send(8'h02);
    idle(1);

    // Strobe on the cycle the timeout would expire: accepted, no error.
    frame_q.push_back({8'h05, 16'h0807});
    send(8'h05); send(8'h07);
    idle(9);
    send(8'h08);
    check("to_edge_valid", {63'd0, frame_valid}, 64'd1);
    check("to_edge_error", {63'd0, frame_error}, 64'd0);
    idle(1);

    // Back-to-back frames on consecutive clocks.
    frame_q.push_back({8'hA0, 16'h0201});
    frame_q.push_back({8'hA1, 16'h1211});
    frame_q.push_back({8'hA2, 16'h2221});
    send(8'hA0); send(8'h01); send(8'h02);
    send(8'hA1); send(8'h11); send(8'h12);
    send(8'hA2); send(8'h21); send(8'h22);
    idle(1);

    // Overrun while the frame is held, then consume plus new opcode.
    frame_ready = 1'b0;
    frame_q.push_back({8'h11, 16'h3322});
    send(8'h11); send(8'h22); send(8'h33);
    idle(2);
    check("hold_valid", {63'd0, frame_valid}, 64'd1);
    err_q.push_back(2'b10);
    send(8'h99);
    check("ovr_error", {63'd0, frame_error}, 64'd1);
    check("ovr_code",  {62'd0, err_code},    64'd2);
    check("ovr_op",    {56'd0, operation},   64'h11);
    check("ovr_opnds", {48'd0, operands},    64'h3322);
    check("ovr_valid", {63'd0, frame_valid}, 64'd1);
    frame_ready = 1'b1;
    frame_q.push_back({8'h2D, 16'h5544});
    send(8'h2D);
    check("sim_valid", {63'd0, frame_valid}, 64'd0);
    check("sim_busy",  {63'd0, busy},        64'd1);
    check("sim_error", {63'd0, frame_error}, 64'd0);
    send(8'h44); send(8'h55);
    check("sim_next_valid", {63'd0, frame_valid}, 64'd1);
    idle(1);

    // Reset in the middle of a frame.
    send(8'hA1); send(8'hA2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, frame_valid}, 64'd0);
    check("mid_rst_busy",  {63'd0, busy},        64'd0);
    check("mid_rst_code",  {62'd0, err_code},    64'd0);
    check("mid_rst_op",    {56'd0, operation},   64'd0);
    check("mid_rst_opnds", {48'd0, operands},    64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    frame_q.push_back({8'h3C, 16'h5A4B});
    send(8'h3C); send(8'h4B); send(8'h5A);
    check("post_rst_valid", {63'd0, frame_valid}, 64'd1);
    idle(2);

    check("frame_q_drained", 64'(frame_q.size()), 64'd0);
    check("wide_q_drained",  64'(wide_q.size()),  64'd0);
    check("err_q_drained",   64'(err_q.size()),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
